rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter sharing one resource. The granted requester is held as a 2-bit index and expanded to a one-hot grant by a 2-to-4 decoder stage. The block sits in front of any shared single-port datapath. Each requester keeps `req` high for as long as it owns the resource and drops it to release.

## Interface
- `MAX_HOLD`, 16, maximum consecutive cycles one owner may hold the grant; ≥1; used only when the timeout is compiled in.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  request/hold lines, bit k = requester k.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `gnt_idx`  out  2  index of current owner, registered; valid only when `gnt_valid`=1.
- `gnt_valid`  out  1  high while any grant is active (equals OR of `gnt`).
- `timeout`  out  1  one-cycle pulse on forced release; tied 0 when `ARB_TIMEOUT_EN` is undefined.

## Operation
- States: IDLE (no owner) and GRANT (owner = `gnt_idx`).
- Reset values: state=IDLE, `gnt`=4'b0000, `gnt_idx`=2'b00, `gnt_valid`=0, `timeout`=0, round-robin pointer `ptr`=0, hold counter=0.
- Arbitration is combinational from the sampled `req`. Search order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4. The first set bit wins.
- IDLE→GRANT: any `req` bit set. The winner is loaded into `gnt_idx`, and `ptr` becomes winner+1 mod 4 (wrap 3→0).
- GRANT, `req[gnt_idx]`=1: hold. `gnt` is unchanged and other requests are ignored.
- GRANT, `req[gnt_idx]`=0 (release):
  - If other requests are pending, the next winner is granted directly on the same edge, with no idle bubble, and `ptr` is updated.
  - Otherwise go to IDLE. `gnt` and `gnt_valid` return to 0, and `gnt_idx` holds its last value.
- The owner re-raising `req` in the same cycle it is released is treated as a fresh request at the lowest rotational priority.
- `gnt` is always the decoded `gnt_idx` gated by `gnt_valid`. It is never multi-hot.
- Requests that are not granted are not latched. A requester that drops `req` before being granted loses its turn.
- Reset mid-grant: all outputs drop to reset values asynchronously. Arbitration restarts from `ptr`=0.

## Timing
- Latency from `req` to `gnt` is 1 clock: `req` sampled at edge N gives `gnt` valid after edge N.
- Release latency is 1 clock: `req[owner]` low at edge N means `gnt` changes after edge N.
- Handoff between requesters takes 0 idle cycles.
- Worst-case wait for a requester holding `req` continuously is 3 other grants.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter increments each cycle in GRANT and clears on every new grant.
  - When it reaches `MAX_HOLD` with `req[owner]` still high, the grant is forcibly released.
  - During that arbitration `req[owner]` is masked, so the next pending requester wins, or the block goes to IDLE if none is pending.
  - `timeout` pulses for 1 cycle, coincident with the new `gnt`.
  - Counter width is $clog2(`MAX_HOLD`+1).
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout`=0.
  - An owner may hold the grant indefinitely.

## Structure
- Shared package `arb_pkg` contains:
  - `arb_state_t` enum {IDLE, GRANT};
  - `NUM_REQ`=4;
  - `IDX_W`=2;
  - `MAX_HOLD` default constant.
- One sub-module, `grant_decoder`: purely combinational 2-to-4 decoder with an enable. It maps `gnt_idx`/`gnt_valid` to `gnt`. Idx 0→0001, 1→0010, 2→0100, 3→1000.

## Test plan
- Reset then `req`=4'b0000 for 5 cycles → `gnt`=0000, `gnt_valid`=0, `timeout`=0 throughout.
- `req`=4'b1111 held; each owner releases for 1 cycle after 2 cycles of hold → grant order 0,1,2,3,0 with `gnt` 0001→0010→0100→1000→0001 and no idle cycle between grants.
- `req`=4'b0100 alone → after 1 edge `gnt`=0100 and `gnt_idx`=2. Drop `req` → `gnt`=0000 next edge. Then `req`=4'b0101 → requester 0 wins (`ptr`=3 wraps to 0).
- Assert `rst` asynchronously mid-grant with `gnt`=1000 → `gnt`=0000 immediately without a clock edge. After release, `req`=4'b1010 → requester 1 granted.
- With `ARB_TIMEOUT_EN` and `MAX_HOLD`=4: requester 2 holds `req` while `req[3]` is also set → after 4 grant cycles `gnt` goes 0100→1000 and `timeout`=1 for exactly 1 cycle.
- Without `ARB_TIMEOUT_EN`, the same stimulus for 50 cycles → `gnt` stays 0100 and `timeout` stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Latency: none (declarations only); backpressure: not applicable.
// Options: none here; ARB_TIMEOUT_EN is consumed by rr_arbiter4.
package arb_pkg;

    localparam int NUM_REQ          = 4;
    localparam int IDX_W            = 2;
    localparam int DEFAULT_MAX_HOLD = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Searches ptr, ptr+1, ... (mod NUM_REQ); the nearest set bit wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter4_grant_decoder.sv
// 2-to-4 decoder with enable: turns the owner index into a one-hot grant.
// Latency: combinational; backpressure: none, output follows inputs.
// Options: none.
module grant_decoder
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter; owners hold req high to keep the resource.
// Latency: 1 clock req->gnt and release->handoff, zero-bubble handoff.
// Backpressure: unserved requests are not latched; ARB_TIMEOUT_EN adds a MAX_HOLD forced release.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] req_masked;
    logic               holding;
    logic               force_rel;
    pick_t              pick;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             timeout_q;

    assign hold_cnt_nxt = hold_cnt_q + CNT_W'(1);
    // Release fires on the edge where the counter would reach MAX_HOLD,
    // so an owner keeps the grant for exactly MAX_HOLD cycles.
    assign force_rel    = (state_q == GRANT) && req[idx_q] &&
                          (hold_cnt_nxt == CNT_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (holding) begin
                hold_cnt_q <= hold_cnt_nxt;
            end else begin
                hold_cnt_q <= '0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign force_rel       = 1'b0;
    assign timeout         = 1'b0;
`endif

    assign holding = (state_q == GRANT) && req[idx_q] && !force_rel;

    // The current owner never competes in its own re-arbitration.
    always_comb begin
        req_masked = req;
        if (state_q == GRANT) begin
            req_masked[idx_q] = 1'b0;
        end
    end

    assign pick = rr_pick(req_masked, ptr_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (!holding) begin
            if (pick.found) begin
                state_d = GRANT;
                idx_d   = pick.idx;
                ptr_d   = pick.idx + IDX_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);

    grant_decoder u_grant_decoder (
        .idx    (idx_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 using vector tables and an expectation queue.
// Latency: checks outputs 1 ns after each rising edge; async reset checked between edges.
// Backpressure: not applicable; expectations for ARB_TIMEOUT_EN follow the same macro.
module tb_rr_arbiter4;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] i, input logic v, input logic t);
        vec_t x;
        x.req = r; x.gnt = g; x.idx = i; x.vld = v; x.to = t;
        return x;
    endfunction

    task automatic check(input string name);
        vec_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty at vector %0d", name, n_vec);
        end else begin
            e = exp_q.pop_front();
            if (gnt !== e.gnt || gnt_idx !== e.idx || gnt_valid !== e.vld || timeout !== e.to) begin
                n_bad++;
                $display("FAIL %s #%0d: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
                         name, n_vec, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.vld, e.to);
            end
        end
    endtask

    task automatic drive(input vec_t v, input string name);
        @(negedge clk);
        req = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Idle, then a full rotation with 2-cycle holds and zero-bubble handoffs.
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0));
        // Single requester, release to idle (idx holds), pointer wrap 3->0.
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0));
        // Requester 0 drops before being served; pointer then favours 3.
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0));

        // Reset state while reset is held.
        #12;
        exp_q.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        check("reset_state");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) drive(tbl[i], "table");

        // Asynchronous reset while gnt=1000, observed before any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        req = 4'b0000;
        #1;
        exp_q.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        check("async_reset");
        @(negedge clk);
        rst = 1'b0;
        drive(mk(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0), "post_reset_ptr0");
        drive(mk(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0), "post_reset_idle");

        // Requester 2 holds while 3 waits.
        drive(mk(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0), "hold_grant");
        for (int i = 0; i < 3; i++) drive(mk(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0), "hold_keep");
`ifdef ARB_TIMEOUT_EN
        drive(mk(4'b1100, 4'b1000, 2'd3, 1'b1, 1'b1), "timeout_handoff");
        drive(mk(4'b1100, 4'b1000, 2'd3, 1'b1, 1'b0), "timeout_pulse_end");
        drive(mk(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0), "timeout_idle");
`else
        for (int i = 0; i < 50; i++) drive(mk(4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0), "no_timeout_hold");
        drive(mk(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0), "no_timeout_idle");
`endif

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
